// File: rtl/systolic_seq_ctrl.sv
// Job sequencer for the skewed NxN systolic core: loads N weight rows, streams M
// activation rows, captures M aligned result rows and reports done/err to the host.
module systolic_seq_ctrl #(
   parameter int N             = 4,
   parameter int DATA_WIDTH    = 8,
   parameter int ACC_WIDTH     = 32,
   parameter int ADDR_WIDTH    = 10,
   parameter int DRAIN_TIMEOUT = 64
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic                      abort,
   input  logic [15:0]               cfg_rows,
   input  logic [ADDR_WIDTH-1:0]     cfg_w_base,
   input  logic [ADDR_WIDTH-1:0]     cfg_x_base,
   input  logic [ADDR_WIDTH-1:0]     cfg_y_base,
   output logic                      busy,
   output logic                      done,
   output logic                      err,
   output logic                      wbuf_rd_en,
   output logic [ADDR_WIDTH-1:0]     wbuf_rd_addr,
   input  logic [N*DATA_WIDTH-1:0]   wbuf_rd_data,
   output logic                      xbuf_rd_en,
   output logic [ADDR_WIDTH-1:0]     xbuf_rd_addr,
   input  logic [N*DATA_WIDTH-1:0]   xbuf_rd_data,
   output logic                      ybuf_wr_en,
   output logic [ADDR_WIDTH-1:0]     ybuf_wr_addr,
   output logic [N*ACC_WIDTH-1:0]    ybuf_wr_data,
   output logic                      core_load_weight,
   output logic [N-1:0]              core_valid_in,
   output logic [N*DATA_WIDTH-1:0]   core_x_in,
   output logic [N*ACC_WIDTH-1:0]    core_y_in,
   input  logic [N*ACC_WIDTH-1:0]    core_y_out,
   input  logic [N-1:0]              core_valid_out
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      LOAD_W   = 3'd1,
      STREAM_X = 3'd2,
      DRAIN    = 3'd3,
      DONE     = 3'd4
   } state_t;

   state_t                state_r, state_s;
   logic [15:0]           rows_r;
   logic [15:0]           rd_cnt_r, rd_cnt_s;
   logic [15:0]           out_cnt_r, out_cnt_s;
   logic [15:0]           idle_cnt_r, idle_cnt_s;
   logic [ADDR_WIDTH-1:0] w_base_r, x_base_r, y_base_r;
   logic                  err_r, err_s;
   logic                  w_beat_r, x_beat_r;
   logic                  busy_s, accept_s, all_ones_s, partial_s, cap_s, extra_s;

   assign busy_s     = (state_r == LOAD_W) || (state_r == STREAM_X) || (state_r == DRAIN);
   assign accept_s   = (state_r == IDLE) && start && (cfg_rows != 16'd0);
   assign all_ones_s = &core_valid_out;
   assign partial_s  = busy_s && (|core_valid_out) && !all_ones_s;
   // A full row is only written while fewer than M rows have been captured.
   assign cap_s      = busy_s && all_ones_s && (out_cnt_r != rows_r);
   assign extra_s    = busy_s && all_ones_s && (out_cnt_r == rows_r);

   // Next-state, counter and sticky-error logic; abort outranks every other exit.
   always_comb begin
      state_s    = state_r;
      rd_cnt_s   = rd_cnt_r;
      out_cnt_s  = cap_s ? (out_cnt_r + 16'd1) : out_cnt_r;
      idle_cnt_s = 16'd0;
      err_s      = err_r | partial_s | extra_s;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               state_s   = LOAD_W;
               rd_cnt_s  = 16'd0;
               out_cnt_s = 16'd0;
               err_s     = 1'b0;
            end else begin
               state_s = IDLE;
            end
         end
         LOAD_W: begin
            if (abort) begin
               state_s = DONE;
               err_s   = 1'b1;
            end else if (rd_cnt_r == 16'(N - 1)) begin
               state_s  = STREAM_X;
               rd_cnt_s = 16'd0;
            end else begin
               rd_cnt_s = rd_cnt_r + 16'd1;
            end
         end
         STREAM_X: begin
            if (abort) begin
               state_s = DONE;
               err_s   = 1'b1;
            end else if (rd_cnt_r == (rows_r - 16'd1)) begin
               state_s  = DRAIN;
               rd_cnt_s = 16'd0;
            end else begin
               rd_cnt_s = rd_cnt_r + 16'd1;
            end
         end
         DRAIN: begin
            if (abort) begin
               state_s = DONE;
               err_s   = 1'b1;
            end else if (out_cnt_s == rows_r) begin
               state_s = DONE;
            end else if (!cap_s && (idle_cnt_r == 16'(DRAIN_TIMEOUT - 1))) begin
               state_s = DONE;
               err_s   = 1'b1;
            end else begin
               idle_cnt_s = cap_s ? 16'd0 : (idle_cnt_r + 16'd1);
            end
         end
         DONE: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State, counters, latched job configuration and read-to-beat delay stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         rows_r     <= 16'd0;
         rd_cnt_r   <= 16'd0;
         out_cnt_r  <= 16'd0;
         idle_cnt_r <= 16'd0;
         w_base_r   <= {ADDR_WIDTH{1'b0}};
         x_base_r   <= {ADDR_WIDTH{1'b0}};
         y_base_r   <= {ADDR_WIDTH{1'b0}};
         err_r      <= 1'b0;
         w_beat_r   <= 1'b0;
         x_beat_r   <= 1'b0;
      end else begin
         state_r    <= state_s;
         rd_cnt_r   <= rd_cnt_s;
         out_cnt_r  <= out_cnt_s;
         idle_cnt_r <= idle_cnt_s;
         err_r      <= err_s;
         w_beat_r   <= wbuf_rd_en;
         x_beat_r   <= xbuf_rd_en;
         if (accept_s) begin
            rows_r   <= cfg_rows;
            w_base_r <= cfg_w_base;
            x_base_r <= cfg_x_base;
            y_base_r <= cfg_y_base;
         end else begin
            rows_r   <= rows_r;
            w_base_r <= w_base_r;
            x_base_r <= x_base_r;
            y_base_r <= y_base_r;
         end
      end
   end

   assign busy = busy_s;
   assign done = (state_r == DONE);
   assign err  = err_r;

   // Reads are pure decodes of registered state; address sums wrap naturally.
   assign wbuf_rd_en   = (state_r == LOAD_W);
   assign wbuf_rd_addr = wbuf_rd_en ? (w_base_r + rd_cnt_r[ADDR_WIDTH-1:0]) : {ADDR_WIDTH{1'b0}};
   assign xbuf_rd_en   = (state_r == STREAM_X);
   assign xbuf_rd_addr = xbuf_rd_en ? (x_base_r + rd_cnt_r[ADDR_WIDTH-1:0]) : {ADDR_WIDTH{1'b0}};

   assign ybuf_wr_en   = cap_s;
   assign ybuf_wr_addr = cap_s ? (y_base_r + out_cnt_r[ADDR_WIDTH-1:0]) : {ADDR_WIDTH{1'b0}};
   assign ybuf_wr_data = cap_s ? core_y_out : {(N*ACC_WIDTH){1'b0}};

   assign core_load_weight = w_beat_r;
   assign core_valid_in    = {N{w_beat_r | x_beat_r}};
   assign core_x_in        = w_beat_r ? wbuf_rd_data :
                             (x_beat_r ? xbuf_rd_data : {(N*DATA_WIDTH){1'b0}});
   assign core_y_in        = {(N*ACC_WIDTH){1'b0}};

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Directed bench for systolic_seq_ctrl: buffer models, a 9-cycle echo core stub
// with injectable rows, and an event log checked against hand-derived timing.
module tb_systolic_seq_ctrl;
   localparam int N   = 4;
   localparam int DW  = 8;
   localparam int AW  = 32;
   localparam int ADW = 10;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              abort = 1'b0;
   logic [15:0]       cfg_rows = 16'd0;
   logic [ADW-1:0]    cfg_w_base = '0, cfg_x_base = '0, cfg_y_base = '0;
   logic              busy, done, err;
   logic              wbuf_rd_en, xbuf_rd_en, ybuf_wr_en;
   logic [ADW-1:0]    wbuf_rd_addr, xbuf_rd_addr, ybuf_wr_addr;
   logic [N*DW-1:0]   wbuf_rd_data = '0, xbuf_rd_data = '0;
   logic [N*AW-1:0]   ybuf_wr_data;
   logic              core_load_weight;
   logic [N-1:0]      core_valid_in, core_valid_out;
   logic [N*DW-1:0]   core_x_in;
   logic [N*AW-1:0]   core_y_in, core_y_out;

   logic              stub_on = 1'b1;
   logic              ovr_en = 1'b0;
   logic [N-1:0]      ovr_valid = '0;
   logic [N*AW-1:0]   ovr_data = '0;
   logic [8:0]        dl_v = '0;
   logic [N*DW-1:0]   dl_d [9];

   int cyc = 0, t0 = 0, checks = 0, errors = 0;
   int wr_c[$], wr_a[$], xr_c[$], xr_a[$], lw_c[$], xb_c[$], yw_c[$], yw_a[$], dn_c[$];
   logic [N*DW-1:0] lw_d[$], xb_d[$];
   logic [N*AW-1:0] yw_d[$];

   systolic_seq_ctrl #(.N(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .ADDR_WIDTH(ADW),
                       .DRAIN_TIMEOUT(64)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .cfg_rows(cfg_rows),
      .cfg_w_base(cfg_w_base), .cfg_x_base(cfg_x_base), .cfg_y_base(cfg_y_base),
      .busy(busy), .done(done), .err(err),
      .wbuf_rd_en(wbuf_rd_en), .wbuf_rd_addr(wbuf_rd_addr), .wbuf_rd_data(wbuf_rd_data),
      .xbuf_rd_en(xbuf_rd_en), .xbuf_rd_addr(xbuf_rd_addr), .xbuf_rd_data(xbuf_rd_data),
      .ybuf_wr_en(ybuf_wr_en), .ybuf_wr_addr(ybuf_wr_addr), .ybuf_wr_data(ybuf_wr_data),
      .core_load_weight(core_load_weight), .core_valid_in(core_valid_in),
      .core_x_in(core_x_in), .core_y_in(core_y_in), .core_y_out(core_y_out),
      .core_valid_out(core_valid_out));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [N*DW-1:0] wdata(input logic [ADW-1:0] a);
      return {4{a[7:0]}} ^ 32'hA5C3_0F69;
   endfunction

   function automatic logic [N*DW-1:0] xdata(input logic [ADW-1:0] a);
      return {a[7:0], a[7:0] + 8'd1, a[7:0] + 8'd2, a[7:0] + 8'd3};
   endfunction

   function automatic logic [N*AW-1:0] expand(input logic [N*DW-1:0] d);
      logic [N*AW-1:0] y;
      for (int i = 0; i < N; i++) y[i*AW +: AW] = 32'h0000_1000 + {24'd0, d[i*DW +: DW]};
      return y;
   endfunction

   // Buffers with one-cycle read latency.
   always @(posedge clk) begin
      wbuf_rd_data <= wbuf_rd_en ? wdata(wbuf_rd_addr) : '0;
      xbuf_rd_data <= xbuf_rd_en ? xdata(xbuf_rd_addr) : '0;
   end

   // Core stub: echoes each activation beat 9 cycles later.
   always @(posedge clk) begin
      dl_v     <= {dl_v[7:0], (core_valid_in == 4'hF) && !core_load_weight};
      dl_d[0]  <= core_x_in;
      for (int i = 1; i < 9; i++) dl_d[i] <= dl_d[i-1];
   end
   assign core_valid_out = ovr_en ? ovr_valid : ((stub_on && dl_v[8]) ? 4'hF : 4'h0);
   assign core_y_out     = ovr_en ? ovr_data : expand(dl_d[8]);

   always @(negedge clk) begin
      if (wbuf_rd_en) begin wr_c.push_back(cyc - t0); wr_a.push_back(int'(wbuf_rd_addr)); end
      if (xbuf_rd_en) begin xr_c.push_back(cyc - t0); xr_a.push_back(int'(xbuf_rd_addr)); end
      if (core_load_weight) begin lw_c.push_back(cyc - t0); lw_d.push_back(core_x_in); end
      else if (core_valid_in != 4'h0) begin xb_c.push_back(cyc - t0); xb_d.push_back(core_x_in); end
      if (ybuf_wr_en) begin
         yw_c.push_back(cyc - t0); yw_a.push_back(int'(ybuf_wr_addr)); yw_d.push_back(ybuf_wr_data);
      end
      if (done) dn_c.push_back(cyc - t0);
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic step_to(input int rel);
      while ((cyc - t0) < rel) step(1);
   endtask

   task automatic clr_logs();
      wr_c.delete(); wr_a.delete(); xr_c.delete(); xr_a.delete(); lw_c.delete(); lw_d.delete();
      xb_c.delete(); xb_d.delete(); yw_c.delete(); yw_a.delete(); yw_d.delete(); dn_c.delete();
   endtask

   task automatic start_job(input int rows, input int wb, input int xb, input int yb);
      cfg_rows = 16'(rows); cfg_w_base = 10'(wb); cfg_x_base = 10'(xb); cfg_y_base = 10'(yb);
      clr_logs();
      t0 = cyc;
      start = 1'b1;
      step(1);
      start = 1'b0;
   endtask

   // Normal M=3 job: x reads 5..7, beats 6..8, stub rows 15..17, done at 18.
   task automatic check_job(input string tag, input int xb, input int yb);
      check({tag, "_xr_n"}, xr_c.size(), 3);
      foreach (xr_c[k]) begin
         check({tag, "_xr_c"}, xr_c[k], 5 + k);
         check({tag, "_xr_a"}, xr_a[k], (xb + k) % 1024);
      end
      check({tag, "_xb_n"}, xb_c.size(), 3);
      foreach (xb_c[k]) begin
         check({tag, "_xb_c"}, xb_c[k], 6 + k);
         check({tag, "_xb_d"}, xb_d[k], xdata(10'(xb + k)));
      end
      check({tag, "_yw_n"}, yw_c.size(), 3);
      foreach (yw_c[k]) begin
         check({tag, "_yw_c"}, yw_c[k], 15 + k);
         check({tag, "_yw_a"}, yw_a[k], (yb + k) % 1024);
         check({tag, "_yw_d"}, yw_d[k], expand(xdata(10'(xb + k))));
      end
      check({tag, "_dn_n"}, dn_c.size(), 1);
      if (dn_c.size() > 0) check({tag, "_dn_c"}, dn_c[0], 18);
   endtask

   initial begin
      // Reset values.
      step(2);
      check("rst_busy", busy, 0);  check("rst_done", done, 0);  check("rst_err", err, 0);
      check("rst_wen", wbuf_rd_en, 0);  check("rst_xen", xbuf_rd_en, 0);
      check("rst_yen", ybuf_wr_en, 0);  check("rst_lw", core_load_weight, 0);
      check("rst_vin", core_valid_in, 0);  check("rst_xin", core_x_in, 0);
      check("rst_yin", core_y_in, 0);  check("rst_wadr", wbuf_rd_addr, 0);
      rst_n = 1'b1;
      step(2);

      // Zero-row start is ignored.
      start_job(0, 10, 20, 30);
      step(5);
      check("zero_busy", busy, 0);  check("zero_wr", wr_c.size(), 0);
      check("zero_xr", xr_c.size(), 0);  check("zero_done", dn_c.size(), 0);

      // Basic job, with a second start (new cfg) asserted while busy.
      start_job(3, 100, 200, 300);
      check("j1_busy1", busy, 1);
      step_to(3);
      start = 1'b1; cfg_x_base = 10'd500; cfg_rows = 16'd7;
      step(1);
      start = 1'b0;
      step_to(25);
      check("j1_wr_n", wr_c.size(), 4);
      foreach (wr_c[k]) begin
         check("j1_wr_c", wr_c[k], 1 + k);
         check("j1_wr_a", wr_a[k], 100 + k);
      end
      check("j1_lw_n", lw_c.size(), 4);
      foreach (lw_c[k]) begin
         check("j1_lw_c", lw_c[k], 2 + k);
         check("j1_lw_d", lw_d[k], wdata(10'(100 + k)));
      end
      check_job("j1", 200, 300);
      check("j1_err", err, 0);  check("j1_busy", busy, 0);

      // Partial valid pattern once: err set, job still completes.
      start_job(3, 40, 60, 80);
      step_to(12);
      ovr_en = 1'b1; ovr_valid = 4'b0011; ovr_data = '1;
      step(1);
      ovr_en = 1'b0;
      check("part_err13", err, 1);
      step_to(25);
      check_job("part", 60, 80);
      check("part_err", err, 1);

      // M+1 early rows: fourth row dropped, err set, done once DRAIN is reached.
      stub_on = 1'b0;
      start_job(3, 0, 0, 700);
      check("extra_errclr", err, 0);
      step_to(2);
      ovr_en = 1'b1; ovr_valid = 4'hF;
      for (int i = 0; i < 4; i++) begin
         ovr_data = {4{32'hC0DE_0000 + 32'(i)}};
         step(1);
      end
      ovr_en = 1'b0;
      check("extra_err", err, 1);
      step_to(12);
      check("extra_yw_n", yw_c.size(), 3);
      foreach (yw_c[k]) begin
         check("extra_yw_c", yw_c[k], 2 + k);
         check("extra_yw_a", yw_a[k], 700 + k);
         check("extra_yw_d", yw_d[k], {4{32'hC0DE_0000 + 32'(k)}});
      end
      check("extra_dn_n", dn_c.size(), 1);
      if (dn_c.size() > 0) check("extra_dn_c", dn_c[0], 9);

      // Drain timeout: DRAIN entered at 8, done at 72.
      start_job(3, 0, 0, 0);
      step_to(75);
      check("to_dn_n", dn_c.size(), 1);
      if (dn_c.size() > 0) check("to_dn_c", dn_c[0], 72);
      check("to_yw_n", yw_c.size(), 0);
      check("to_err", err, 1);
      stub_on = 1'b1;

      // Abort at r=1 in STREAM_X.
      start_job(3, 0, 10, 20);
      step_to(6);
      abort = 1'b1;
      step(1);
      abort = 1'b0;
      check("ab_done", done, 1);
      step_to(22);
      check("ab_xr_n", xr_c.size(), 2);
      check("ab_xb_n", xb_c.size(), 2);
      if (xb_c.size() > 1) check("ab_xb_c", xb_c[1], 7);
      check("ab_dn_n", dn_c.size(), 1);
      if (dn_c.size() > 0) check("ab_dn_c", dn_c[0], 7);
      check("ab_yw_n", yw_c.size(), 0);
      check("ab_err", err, 1);

      // Recovery job clears err and runs normally.
      start_job(3, 5, 30, 50);
      check("rec_err1", err, 0);
      step_to(25);
      check_job("rec", 30, 50);
      check("rec_err", err, 0);

      // Asynchronous reset mid-LOAD_W (with err already set).
      start_job(3, 5, 30, 50);
      ovr_en = 1'b1; ovr_valid = 4'b0011;
      step(1);
      ovr_en = 1'b0;
      check("mr_err_pre", err, 1);
      rst_n = 1'b0;
      #1;
      check("mr_busy", busy, 0);  check("mr_err", err, 0);  check("mr_wen", wbuf_rd_en, 0);
      check("mr_wadr", wbuf_rd_addr, 0);  check("mr_lw", core_load_weight, 0);
      check("mr_vin", core_valid_in, 0);  check("mr_xin", core_x_in, 0);
      step(1);
      rst_n = 1'b1;
      step(10);
      check("mr_dn_n", dn_c.size(), 0);
      check("mr_wr_n", wr_c.size(), 1);
      check("mr_busy2", busy, 0);

      // Address wrap on activation and result buffers.
      start_job(3, 0, 1023, 1022);
      step_to(25);
      check_job("wrap", 1023, 1022);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
